// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration-time parameter checks for the single-clock FIFO.
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   function automatic bit depth_is_pow2(input int unsigned depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit thresh_ok(input int unsigned ae, input int unsigned af,
                                    input int unsigned depth);
      return (ae < af) && (af <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module sync_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count, almost/sticky flags and registered read.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   if (!depth_is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
      $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   localparam logic [PTR_WIDTH:0] PtrOne = {{PTR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_WIDTH:0] AfLvl  = AF_THRESH[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] AeLvl  = AE_THRESH[PTR_WIDTH:0];

   logic [PTR_WIDTH:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic [PTR_WIDTH:0]    level;
   logic [DATA_WIDTH-1:0] ram_rdata;
   fifo_status_t          status;

   // Flags derive from registered pointers only, so full and empty are never both set.
   always_comb begin
      level               = wptr_q - rptr_q;
      status              = '0;
      status.empty        = (wptr_q == rptr_q);
      status.full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                            (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
      status.almost_full  = (level >= AfLvl);
      status.almost_empty = (level <= AeLvl);
      status.overflow     = overflow_q;
      status.underflow    = underflow_q;
   end

   always_comb begin
      wr_acc      = wr_en && !status.full;
      rd_acc      = rd_en && !status.empty;
      wptr_d      = wr_acc ? wptr_q + PtrOne : wptr_q;
      rptr_d      = rd_acc ? rptr_q + PtrOne : rptr_q;
      overflow_d  = overflow_q  || (wr_en && status.full);
      underflow_d = underflow_q || (rd_en && status.empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (PTR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr_q[PTR_WIDTH-1:0]),
      .wdata (data_in),
      .raddr (rptr_q[PTR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = ram_rdata;
   assign rd_valid = !status.empty;
`else
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  rd_valid_q;

   always_comb begin
      dout_d = rd_acc ? ram_rdata : dout_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         rd_valid_q <= rd_acc;
      end
   end

   assign data_out = dout_q;
   assign rd_valid = rd_valid_q;
`endif

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = status.overflow;
   assign underflow    = status.underflow;
   assign count        = level;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: queue-based reference model, negedge monitor.
module tb_sync_fifo_param;

   localparam int unsigned DW  = 8;
   localparam int unsigned DEP = 8;
   localparam int unsigned AF  = 6;
   localparam int unsigned AE  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0]    count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   bit            m_ovf = 0;
   bit            m_udf = 0;
   bit            m_rv  = 0;
   bit            mon_en = 0;

   sync_fifo_param #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEP),
      .PTR_WIDTH  (3),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
      bit was_full;
      bit was_empty;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      @(posedge clk);
      was_full  = (mq.size() == DEP);
      was_empty = (mq.size() == 0);
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      m_rv = r && !was_empty;
      if (m_rv) begin
`ifdef SYNC_FIFO_FWFT_EN
         void'(mq.pop_front());
`else
         exp_q.push_back(mq.pop_front());
`endif
      end
      if (w && !was_full) mq.push_back(d);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      mq.delete();
      exp_q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_rv  = 0;
      #1 rst = 1'b0;
      mon_en = 1;
`ifndef SYNC_FIFO_FWFT_EN
      @(negedge clk);
      check("dout_after_reset", data_out, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("count", count, mq.size());
         check("full", full, mq.size() == DEP);
         check("empty", empty, mq.size() == 0);
         check("almost_full", almost_full, mq.size() >= AF);
         check("almost_empty", almost_empty, mq.size() <= AE);
         check("overflow", overflow, m_ovf);
         check("underflow", underflow, m_udf);
`ifdef SYNC_FIFO_FWFT_EN
         check("rd_valid", rd_valid, mq.size() != 0);
         if (mq.size() != 0) check("fwft_head", data_out, mq[0]);
`else
         check("rd_valid", rd_valid, m_rv);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_read", 1, 0);
            else check("read_data", data_out, exp_q.pop_front());
         end
`endif
      end
   end

   initial begin
      logic [DW-1:0] d;
      int n;
      @(posedge clk);
      do_reset();

      // Fill to full, overflow attempt, drain, underflow attempt
      for (int i = 1; i <= 8; i++) cycle(1, DW'(i), 0);
      cycle(1, 8'hAA, 0);
      for (int i = 0; i < 8; i++) cycle(0, '0, 1);
      cycle(0, '0, 1);

      // Steady-state simultaneous traffic at level 5; pointers wrap repeatedly
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, DW'($urandom), 0);
      for (int i = 0; i < 20; i++) cycle(1, DW'($urandom), 1);
      n = mq.size();
      for (int i = 0; i < n; i++) cycle(0, '0, 1);

      // Full + both -> read only; empty + both -> write only
      for (int i = 0; i < 8; i++) cycle(1, DW'(8'h10 + i), 0);
      cycle(1, 8'hEE, 1);
      n = mq.size();
      for (int i = 0; i < n; i++) cycle(0, '0, 1);
      cycle(1, 8'h77, 1);
      cycle(0, '0, 1);

      // Reset mid-operation discards contents
      for (int i = 0; i < 3; i++) cycle(1, DW'(8'h30 + i), 0);
      do_reset();
      cycle(1, 8'h55, 0);
      cycle(0, '0, 1);
      cycle(0, '0, 0);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         d = DW'($urandom);
         cycle(bit'($urandom_range(0, 99) < 55), d, bit'($urandom_range(0, 99) < 50));
      end

      n = mq.size();
      for (int i = 0; i < n; i++) cycle(0, '0, 1);
      cycle(0, '0, 0);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
